input_conditioner: RTL and testbench

Front-end stage directly upstream of the player controller. Synchronises the two raw push-button inputs (up, down) into the core clock domain, debounces them, and presents clean `button_up` / `button_down` levels sampled by the controller on `game_tick[0]`. Optionally holds short presses until the next game tick so no press is lost between ticks.

---
 rtl/dino_pkg.sv | 11 +
 rtl/button_debounce.sv | 107 ++++++++++
 rtl/input_conditioner.sv | 59 +++++
 tb/tb_input_conditioner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants for the dino game front end: game-tick bit positions, button indices
// and the default debounce length.
package dino_pkg;

  localparam int unsigned TICK_SAMPLE             = 0;
  localparam int unsigned TICK_UPDATE             = 1;
  localparam int unsigned BTN_UP                  = 0;
  localparam int unsigned BTN_DOWN                = 1;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/button_debounce.sv
// One button channel: synchroniser, debounce counter, accepted level, rising-edge detect.
// Optional press hold until the next sample tick when INPUT_CONDITIONER_PRESS_LATCH_EN is defined.
module button_debounce
  import dino_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick_sample,
  input  logic i_raw,
  output logic o_button,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_db;
  logic                   r_button;
  logic                   r_rise;

  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_db_next;
  logic                   w_rise;
  logic                   w_sync;
  logic                   w_hold;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Any cycle of agreement with the accepted level restarts the qualification count.
  always_comb begin
    w_db_next  = r_db;
    w_cnt_next = '0;
    if (w_sync != r_db) begin
      if (r_cnt == CNT_LAST) begin
        w_db_next = w_sync;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
    w_rise = w_db_next & ~r_db;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_db  <= w_db_next;
    end
  end

`ifdef INPUT_CONDITIONER_PRESS_LATCH_EN
  logic r_pend;
  logic w_pend_next;

  always_comb begin
    w_pend_next = r_pend;
    if (w_rise) begin
      w_pend_next = 1'b1;
    end else if (i_tick_sample) begin
      w_pend_next = 1'b0;
    end
    // Drop the hold on the same edge the controller samples the tick.
    w_hold = r_pend & ~(i_tick_sample & ~w_rise);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
    end
  end
`else
  logic w_unused_tick;
  assign w_unused_tick = i_tick_sample;
  assign w_hold        = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_button <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_button <= r_db | w_hold;
      r_rise   <= w_rise;
    end
  end

  assign o_button = r_button;
  assign o_rise   = r_rise;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the up/down push buttons for the player controller.
// Press latching is enabled by defining INPUT_CONDITIONER_PRESS_LATCH_EN.
module input_conditioner
  import dino_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_game_tick,
  input  logic       i_btn_up_raw,
  input  logic       i_btn_down_raw,
  output logic       o_button_up,
  output logic       o_button_down,
  output logic       o_press_pulse
);

  logic [1:0] w_rise;
  logic       r_press_pulse;
  logic       w_unused_tick;

  assign w_unused_tick = i_game_tick[TICK_UPDATE];

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_up (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_tick_sample (i_game_tick[TICK_SAMPLE]),
    .i_raw         (i_btn_up_raw),
    .o_button      (o_button_up),
    .o_rise        (w_rise[BTN_UP])
  );

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_down (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_tick_sample (i_game_tick[TICK_SAMPLE]),
    .i_raw         (i_btn_down_raw),
    .o_button      (o_button_down),
    .o_rise        (w_rise[BTN_DOWN])
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_press_pulse <= 1'b0;
    end else begin
      r_press_pulse <= w_rise[BTN_UP] | w_rise[BTN_DOWN];
    end
  end

  assign o_press_pulse = r_press_pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Outputs are compared as {button_up, button_down, press_pulse}.
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic [1:0] game_tick;
  logic       up_raw;
  logic       down_raw;
  logic       button_up;
  logic       button_down;
  logic       press_pulse;

  int n_err    = 0;
  int n_checks = 0;

  input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_game_tick    (game_tick),
    .i_btn_up_raw   (up_raw),
    .i_btn_down_raw (down_raw),
    .o_button_up    (button_up),
    .o_button_down  (button_down),
    .o_press_pulse  (press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {5'b0, button_up, button_down, press_pulse};
  endfunction

  logic [7:0] exp_latch;

  initial begin
    reset     = 1'b1;
    game_tick = 2'b00;
    up_raw    = 1'b0;
    down_raw  = 1'b0;
    step(2);
    chk("reset_state", outs(), 8'b000);
    reset = 1'b0;

    // Reset mid-hold: outputs clear at once, held button re-qualifies from scratch.
    up_raw = 1'b1;
    step(20);
    chk("held_before_reset", outs(), 8'b100);
    #2 reset = 1'b1;
    #1 chk("async_reset_clears", outs(), 8'b000);
    #2 reset = 1'b0;
    step(6);
    chk("requal_not_yet", outs(), 8'b000);
    step(1);
    chk("requal_rise", outs(), 8'b101);
    step(1);
    chk("requal_pulse_end", outs(), 8'b100);
    up_raw = 1'b0;
    step(12);
    chk("requal_released", outs(), 8'b000);

    // Clean press and release.
    up_raw = 1'b1;
    step(6);
    chk("press_not_yet", outs(), 8'b000);
    step(1);
    chk("press_rise", outs(), 8'b101);
    step(1);
    chk("press_pulse_end", outs(), 8'b100);
    step(4);
    up_raw = 1'b0;
    step(6);
    chk("release_not_yet", outs(), 8'b100);
    step(1);
    chk("release_fall", outs(), 8'b000);

    // Bounce on down: two-cycle runs never qualify.
    for (int i = 0; i < 12; i++) begin
      down_raw = ((i / 2) % 2) == 0;
      step(1);
      chk("bounce_quiet", outs(), 8'b000);
    end
    down_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("bounce_settle_quiet", outs(), 8'b000);
    end
    step(1);
    chk("bounce_rise", outs(), 8'b011);
    step(1);
    chk("bounce_pulse_end", outs(), 8'b010);
    down_raw = 1'b0;
    step(12);
    chk("bounce_released", outs(), 8'b000);

    // Three-cycle glitch is rejected and the counter clears.
    up_raw = 1'b1;
    step(3);
    up_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_quiet", outs(), 8'b000);
    end
    chk("glitch_cnt_zero", 8'(u_dut.u_up.r_cnt), 8'd0);

    // Simultaneous press: both rise together, one pulse.
    up_raw   = 1'b1;
    down_raw = 1'b1;
    step(6);
    chk("simul_not_yet", outs(), 8'b000);
    step(1);
    chk("simul_rise", outs(), 8'b111);
    step(1);
    chk("simul_pulse_end", outs(), 8'b110);
    step(3);
    chk("simul_hold", outs(), 8'b110);
    up_raw   = 1'b0;
    down_raw = 1'b0;
    step(12);
    chk("simul_released", outs(), 8'b000);

    // Eight-cycle press with a sample tick sampled 39 edges after the press starts.
    up_raw = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 8) up_raw = 1'b0;
      game_tick = (i == 39) ? 2'b01 : (i == 40) ? 2'b10 : 2'b00;
      step(1);
`ifdef INPUT_CONDITIONER_PRESS_LATCH_EN
      exp_latch = 8'b100;
`else
      exp_latch = 8'b000;
`endif
      if (i == 5)  chk("short_not_yet", outs(), 8'b000);
      if (i == 6)  chk("short_rise", outs(), 8'b101);
      if (i == 13) chk("short_last_high", outs(), 8'b100);
      if (i == 14) chk("short_after_release", outs(), exp_latch);
      if (i == 38) chk("short_before_tick", outs(), exp_latch);
      if (i == 39) chk("short_at_tick", outs(), 8'b000);
      if (i == 59) chk("short_idle", outs(), 8'b000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
